// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the AXI4-Lite master arbiter.
package axi_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RADDR,
        RDATA,
        WADDR,
        WRESP,
        DONE
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_EXOKAY = 2'd1;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    localparam int STAT_W = 16;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant selection: search starts one past the last winner.
module rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] grant
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IW-1:0] last_q;

    always_comb begin
        int idx;
        grant = '0;
        idx   = 0;
        for (int off = 1; off <= NREQ; off++) begin
            idx = (int'(last_q) + off) % NREQ;
            if (grant == '0 && req[idx])
                grant[idx] = 1'b1;
        end
    end

    // Reset points at the highest index so requester 0 is searched first.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= IW'(NREQ - 1);
        end else if (advance) begin
            for (int i = 0; i < NREQ; i++)
                if (grant[i])
                    last_q <= IW'(i);
        end
    end

endmodule

// File: rtl/axi4lite_master_arbiter.sv
// Single-outstanding AXI4-Lite master shared by NREQ requesters.
// Define AXI_ARB_STATS_EN to add grant_cnt / err_cnt statistics outputs.
module axi4lite_master_arbiter
    import axi_arb_pkg::*;
#(
    parameter int AW   = 32,
    parameter int DW   = 32,
    parameter int NREQ = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ-1:0]           we,
    input  logic [NREQ-1:0][AW-1:0]   addr,
    input  logic [NREQ-1:0][DW-1:0]   wdata,
    output logic [NREQ-1:0]           ack,
    output logic [DW-1:0]             rdata,
    output logic [1:0]                resp,
    output logic [AW-1:0]             m_araddr,
    output logic [2:0]                m_arprot,
    output logic                      m_arvalid,
    input  logic                      m_arready,
    input  logic [DW-1:0]             m_rdata,
    input  logic [1:0]                m_rresp,
    input  logic                      m_rvalid,
    output logic                      m_rready,
    output logic [AW-1:0]             m_awaddr,
    output logic [2:0]                m_awprot,
    output logic                      m_awvalid,
    input  logic                      m_awready,
    output logic [DW-1:0]             m_wdata,
    output logic [DW/8-1:0]           m_wstrb,
    output logic                      m_wvalid,
    input  logic                      m_wready,
    input  logic [1:0]                m_bresp,
    input  logic                      m_bvalid,
    output logic                      m_bready
`ifdef AXI_ARB_STATS_EN
    ,
    output logic [NREQ-1:0][STAT_W-1:0] grant_cnt,
    output logic [STAT_W-1:0]           err_cnt
`endif
);

    state_t            state_q, state_d;
    logic [NREQ-1:0]   grant, gnt_q;
    logic              start;
    logic              we_q;
    logic [AW-1:0]     addr_q;
    logic [DW-1:0]     wdata_q;
    logic              aw_done_q, w_done_q;
    logic              sel_we;
    logic [AW-1:0]     sel_addr;
    logic [DW-1:0]     sel_wdata;

    assign start = (state_q == IDLE) && (|req);

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .advance (start),
        .grant   (grant)
    );

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_we    = we[i];
                sel_addr  = addr[i];
                sel_wdata = wdata[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = sel_we ? WADDR : RADDR;
            RADDR:   if (m_arready) state_d = RDATA;
            RDATA:   if (m_rvalid) state_d = DONE;
            // AW and W may be accepted in either order or in the same cycle.
            WADDR:   if ((aw_done_q || m_awready) && (w_done_q || m_wready)) state_d = WRESP;
            WRESP:   if (m_bvalid) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata     <= '0;
            resp      <= RESP_OKAY;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    aw_done_q <= 1'b0;
                    w_done_q  <= 1'b0;
                    if (start) begin
                        gnt_q   <= grant;
                        we_q    <= sel_we;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                    end
                end
                WADDR: begin
                    aw_done_q <= aw_done_q | m_awready;
                    w_done_q  <= w_done_q | m_wready;
                end
                RDATA: if (m_rvalid) begin
                    rdata <= m_rdata;
                    resp  <= m_rresp;
                end
                WRESP: if (m_bvalid) resp <= m_bresp;
                default: ;
            endcase
        end
    end

    assign m_araddr  = addr_q;
    assign m_arprot  = 3'b000;
    assign m_arvalid = (state_q == RADDR);
    assign m_rready  = (state_q == RDATA);
    assign m_awaddr  = addr_q;
    assign m_awprot  = 3'b000;
    assign m_awvalid = (state_q == WADDR) && !aw_done_q;
    assign m_wdata   = wdata_q;
    assign m_wstrb   = '1;
    assign m_wvalid  = (state_q == WADDR) && !w_done_q;
    assign m_bready  = (state_q == WRESP);
    assign ack       = (state_q == DONE) ? gnt_q : '0;

`ifdef AXI_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++)
                if (start && grant[i])
                    grant_cnt[i] <= sat_inc(grant_cnt[i]);
            if (state_q == DONE && resp != RESP_OKAY)
                err_cnt <= sat_inc(err_cnt);
        end
    end
`endif

    logic unused_we_q;
    assign unused_we_q = we_q;

endmodule

// File: tb/tb_axi4lite_master_arbiter.sv
// Scoreboard bench for axi4lite_master_arbiter with a reactive AXI4-Lite slave model.
module tb_axi4lite_master_arbiter;
    import axi_arb_pkg::*;

    localparam int AW = 32, DW = 32, NREQ = 2;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NREQ-1:0]         req, we, ack;
    logic [NREQ-1:0][AW-1:0] addr;
    logic [NREQ-1:0][DW-1:0] wdata;
    logic [DW-1:0]           rdata;
    logic [1:0]              resp;
    logic [AW-1:0]           m_araddr, m_awaddr;
    logic [2:0]              m_arprot, m_awprot;
    logic                    m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready;
    logic                    m_arready = 0, m_rvalid = 0, m_awready = 0, m_wready = 0, m_bvalid = 0;
    logic [DW-1:0]           m_rdata = '0, m_wdata;
    logic [1:0]              m_rresp = '0, m_bresp = '0;
    logic [DW/8-1:0]         m_wstrb;
`ifdef AXI_ARB_STATS_EN
    logic [NREQ-1:0][STAT_W-1:0] grant_cnt;
    logic [STAT_W-1:0]           err_cnt;
`endif

    always #5 clk = ~clk;

    axi4lite_master_arbiter #(.AW(AW), .DW(DW), .NREQ(NREQ)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack), .rdata(rdata), .resp(resp),
        .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
`ifdef AXI_ARB_STATS_EN
        , .grant_cnt(grant_cnt), .err_cnt(err_cnt)
`endif
    );

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        int          id;
        logic [31:0] rd;
        logic [1:0]  rs;
    } exp_t;
    exp_t sbq[$];
    exp_t e;
    int   overlap = 0;

    always @(negedge clk) begin
        if (!reset && ack !== '0) begin
            if (sbq.size() == 0) begin
                chk("unexpected_ack", 64'(ack), 64'd0);
            end else begin
                e = sbq.pop_front();
                chk("ack_id", 64'(ack), 64'(2'b01 << e.id));
                chk("rdata", 64'(rdata), 64'(e.rd));
                chk("resp", 64'(resp), 64'(e.rs));
            end
        end
        if ((m_arvalid || m_rready) && (m_awvalid || m_wvalid || m_bready)) overlap++;
        if ($countones(ack) > 1) overlap++;
    end

    // ---------------- slave model (drives on negedge) ----------------
    int   ar_lat = 0, r_lat = 0, aw_lat = 0, w_lat = 0;
    logic [1:0] cur_rresp = RESP_OKAY, cur_bresp = RESP_OKAY;
    int   ar_cnt, r_cnt, aw_cnt, w_cnt;
    logic ar_hs, r_hs, aw_hs, w_hs, b_hs, r_pend, b_pend, aw_ok, w_ok, w_drop_seen;
    logic [AW-1:0] r_addr, seen_awaddr;
    logic [DW-1:0] seen_wdata;
    logic [DW/8-1:0] seen_wstrb;

    function automatic logic [31:0] rdata_fn(input logic [31:0] a);
        return (a == 32'h10) ? 32'h1234_5678 : (a ^ 32'hA5A5_0000);
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            m_arready = 0; m_rvalid = 0; m_awready = 0; m_wready = 0; m_bvalid = 0;
            ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0;
            ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0;
            r_pend = 0; b_pend = 0; aw_ok = 0; w_ok = 0;
        end else begin
            if (r_hs) m_rvalid = 0;
            if (b_hs) m_bvalid = 0;
            if (ar_hs) begin r_pend = 1; r_cnt = 0; end
            if (aw_hs) aw_ok = 1;
            if (w_hs) w_ok = 1;
            if (aw_ok && w_ok) begin b_pend = 1; aw_ok = 0; w_ok = 0; end
            if (m_arvalid) begin m_arready = (ar_cnt >= ar_lat); ar_cnt++; end
            else begin m_arready = 0; ar_cnt = 0; end
            ar_hs = m_arvalid && m_arready;
            if (ar_hs) r_addr = m_araddr;
            if (r_pend) begin
                if (r_cnt >= r_lat) begin
                    m_rvalid = 1; m_rdata = rdata_fn(r_addr); m_rresp = cur_rresp; r_pend = 0;
                end else r_cnt++;
            end
            r_hs = m_rvalid && m_rready;
            if (m_awvalid) begin m_awready = (aw_cnt >= aw_lat); aw_cnt++; end
            else begin m_awready = 0; aw_cnt = 0; end
            aw_hs = m_awvalid && m_awready;
            if (aw_hs) seen_awaddr = m_awaddr;
            if (m_wvalid) begin m_wready = (w_cnt >= w_lat); w_cnt++; end
            else begin m_wready = 0; w_cnt = 0; end
            w_hs = m_wvalid && m_wready;
            if (w_hs) begin seen_wdata = m_wdata; seen_wstrb = m_wstrb; end
            if (m_awvalid && !m_wvalid) w_drop_seen = 1;
            if (b_pend) begin m_bvalid = 1; m_bresp = cur_bresp; b_pend = 0; end
            b_hs = m_bvalid && m_bready;
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input int id, input logic w, input logic [31:0] a, input logic [31:0] wd);
        req[id] = 1'b1; we[id] = w; addr[id] = a; wdata[id] = wd;
    endtask

    task automatic wait_ack(input int id, output int k);
        k = 0;
        while (ack[id] !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) chk("ack_timeout", 64'(k), 64'd0);
    endtask

    task automatic wait_acks(input int n, input string name);
        int got = 0, t = 0;
        while (got < n && t < 400) begin
            @(negedge clk);
            t++;
            if (ack !== '0) got++;
        end
        chk(name, 64'(got), 64'(n));
    endtask

    int k;
`ifdef AXI_ARB_STATS_EN
    logic [STAT_W-1:0] g0_snap, err_snap;
`endif

    initial begin
        req = '0; we = '0; addr = '0; wdata = '0; w_drop_seen = 0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_resp", 64'(resp), 64'd0);
        chk("rst_arvalid", 64'(m_arvalid), 64'd0);
        chk("rst_awvalid", 64'(m_awvalid), 64'd0);
        chk("rst_wvalid", 64'(m_wvalid), 64'd0);
        chk("rst_rready", 64'(m_rready), 64'd0);
        chk("rst_bready", 64'(m_bready), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Read, zero-wait slave: req cycle + 3 edges to the ack cycle = 4 cycles.
        sbq.push_back('{0, 32'h1234_5678, RESP_OKAY});
        issue(0, 1'b0, 32'h10, 32'h0);
        wait_ack(0, k);
        chk("read_latency_edges", 64'(k), 64'd3);
        req[0] = 1'b0;
        @(negedge clk);

        // Write, W accepted 3 cycles before AW; rdata must be kept.
        aw_lat = 3; w_lat = 0; w_drop_seen = 0;
        sbq.push_back('{1, 32'h1234_5678, RESP_OKAY});
        issue(1, 1'b1, 32'h1C, 32'hFFFF_FFF9);
        wait_ack(1, k);
        req[1] = 1'b0;
        chk("awaddr", 64'(seen_awaddr), 64'h1C);
        chk("wdata_bus", 64'(seen_wdata), 64'hFFFF_FFF9);
        chk("wstrb", 64'(seen_wstrb), 64'hF);
        chk("wvalid_drop_first", 64'(w_drop_seen), 64'd1);
        aw_lat = 0;
        @(negedge clk);

        // Round robin: last grant was 1, so order is 0,1,0,1.
        sbq.push_back('{0, 32'hA5A5_0040, RESP_OKAY});
        sbq.push_back('{1, 32'hA5A5_0040, RESP_OKAY});
        sbq.push_back('{0, 32'hA5A5_0040, RESP_OKAY});
        sbq.push_back('{1, 32'hA5A5_0040, RESP_OKAY});
        issue(0, 1'b0, 32'h40, 32'h0);
        issue(1, 1'b1, 32'h80, 32'h55);
        wait_acks(4, "rr_acks");
        req = '0;
        repeat (3) @(negedge clk);

        // Error response passes through unmodified.
`ifdef AXI_ARB_STATS_EN
        g0_snap = grant_cnt[0]; err_snap = err_cnt;
`endif
        cur_rresp = RESP_SLVERR;
        sbq.push_back('{0, 32'hA5A5_0020, RESP_SLVERR});
        issue(0, 1'b0, 32'h20, 32'h0);
        wait_ack(0, k);
        req[0] = 1'b0;
        cur_rresp = RESP_OKAY;
        @(negedge clk);
`ifdef AXI_ARB_STATS_EN
        chk("err_cnt_delta", 64'(err_cnt - err_snap), 64'd1);
        chk("grant0_delta", 64'(grant_cnt[0] - g0_snap), 64'd1);
`endif

        // Reset during RDATA: transaction abandoned, no ack.
        r_lat = 5;
        issue(0, 1'b0, 32'h30, 32'h0);
        k = 0;
        while (m_rready !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        chk("reach_rdata", 64'(m_rready), 64'd1);
        reset = 1'b1; req = '0;
        @(negedge clk);
        chk("midrst_ack", 64'(ack), 64'd0);
        chk("midrst_arvalid", 64'(m_arvalid), 64'd0);
        chk("midrst_rready", 64'(m_rready), 64'd0);
        chk("midrst_awvalid", 64'(m_awvalid), 64'd0);
        chk("midrst_wvalid", 64'(m_wvalid), 64'd0);
        chk("midrst_bready", 64'(m_bready), 64'd0);
        chk("midrst_rdata", 64'(rdata), 64'd0);
        r_lat = 0;
        reset = 1'b0;
        @(negedge clk);

        // After reset requester 0 wins first, then requester 1.
        sbq.push_back('{0, 32'hA5A5_0044, RESP_OKAY});
        sbq.push_back('{1, 32'hA5A5_0048, RESP_OKAY});
        issue(0, 1'b0, 32'h44, 32'h0);
        issue(1, 1'b0, 32'h48, 32'h0);
        wait_acks(2, "post_rst_acks");
        req = '0;
        repeat (5) @(negedge clk);

        chk("arprot", 64'(m_arprot), 64'd0);
        chk("awprot", 64'(m_awprot), 64'd0);
        chk("single_outstanding", 64'(overlap), 64'd0);
        chk("sb_empty", 64'(sbq.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/axi4lite_master_arbiter.md
AXI4LITE_MASTER_ARBITER -- requirements
Module: axi4lite_master_arbiter

Interface
REQ-001 Parameters SHALL be: AW, default 32, address width; DW, default 32, data width (32 only); NREQ, default 2, requester count (2 only).
REQ-002 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be:
  - clk  in  1  rising-edge clock
  - reset  in  1  synchronous active-high reset
  - req  in  [NREQ]  request, per requester
  - we  in  [NREQ]  1 = write, 0 = read
  - addr  in  [NREQ][AW]  byte address
  - wdata  in  [NREQ][DW]  write data
  - ack  out  [NREQ]  one-cycle completion pulse
  - rdata  out  DW  read data, valid with ack
  - resp  out  2  AXI response, valid with ack
  - m_araddr/m_arprot/m_arvalid/m_arready, m_rdata/m_rresp/m_rvalid/m_rready, m_awaddr/m_awprot/m_awvalid/m_awready, m_wdata/m_wstrb/m_wvalid/m_wready, m_bresp/m_bvalid/m_bready  AXI4-Lite master, standard directions and widths.

Function
REQ-004 FSM states SHALL be IDLE, RADDR, RDATA, WADDR, WRESP, DONE.
REQ-005 In IDLE with any req high, the arbiter SHALL grant one requester, latch its we/addr/wdata in the same cycle, then go to RADDR (we = 0) or WADDR (we = 1) on the next clock.
REQ-006 Arbitration SHALL be round-robin: with both requesting, grant goes to the requester not granted last. After reset, requester 0 has priority.
REQ-007 RADDR: m_arvalid SHALL be 1 with m_araddr = latched addr until m_arready is sampled high, then go to RDATA.
REQ-008 RDATA: m_rready SHALL be 1. On m_rvalid, capture m_rdata into rdata and m_rresp into resp, then go to DONE.
REQ-009 WADDR: m_awvalid and m_wvalid SHALL assert together. Each SHALL drop independently on its own ready. Go to WRESP when both have been accepted; same-cycle acceptance of both is allowed.
REQ-010 WRESP: m_bready SHALL be 1. On m_bvalid, capture m_bresp into resp, leave rdata unchanged, then go to DONE.
REQ-011 DONE: ack[granted] SHALL pulse for exactly one cycle, then the FSM returns to IDLE. Minimum read latency (req to ack) is 4 cycles with zero-wait slave ready.
REQ-012 m_arprot and m_awprot SHALL be 0, and m_wstrb SHALL be all ones.
REQ-013 m_rready and m_bready SHALL be 0 outside RDATA and WRESP respectively.
REQ-014 The arbiter SHALL have at most one outstanding transaction at any time.
REQ-015 req deasserting after grant SHALL NOT abort the transaction, and ack is still issued.
REQ-016 A requester holding req through ack SHALL be eligible in the IDLE cycle that follows, subject to round-robin.
REQ-017 A non-OKAY resp SHALL be passed through unmodified, with no retry.

Reset
REQ-018 Reset SHALL force: state IDLE; all m_*valid, m_rready, m_bready, and ack to 0; rdata and resp to 0; last-grant pointer to 1, so requester 0 wins first.
REQ-019 Reset asserted mid-transaction SHALL abandon the transaction with no ack. Slave-side cleanup is the system's reset responsibility.

Configuration
REQ-020 With AXI_ARB_STATS_EN defined, the block SHALL add outputs grant_cnt[NREQ][16] and err_cnt[16].
  - grant_cnt increments per grant and saturates at 0xFFFF.
  - err_cnt increments on each ack with resp != OKAY and saturates.
  - Both counters clear on reset.
REQ-021 Without AXI_ARB_STATS_EN, those ports and counters SHALL be absent and all other behaviour identical.

Structure
REQ-022 Package axi_arb_pkg SHALL hold:
  - the state enum;
  - response constants RESP_OKAY = 0, RESP_EXOKAY = 1, RESP_SLVERR = 2, RESP_DECERR = 3;
  - the stats counter width constant 16.
REQ-023 Sub-module rr_arbiter (inputs req, advance; output one-hot grant; internal last-grant register) SHALL implement REQ-006.
REQ-024 Address/data capture and the FSM SHALL remain in the top module.

Verification
REQ-025 Read path: req[0]=1, we=0, addr=0x10; slave returns arready at once and rdata=0x1234_5678 OKAY one cycle later -> ack[0] 4 cycles after req, rdata=0x12345678, resp=0.
REQ-026 Write path: req[1]=1, we=1, addr=0x1C, wdata=0xFFFF_FFF9; wready 3 cycles before awready -> wvalid drops first, awvalid held; bresp=0 -> ack[1] one pulse, m_awaddr=0x1C.
REQ-027 Round-robin: both req held high for 4 transactions -> grant order 0,1,0,1, exactly one ack per transaction, never two outstanding.
REQ-028 Error: slave returns rresp=2 -> resp=2 at ack; with AXI_ARB_STATS_EN, err_cnt=1 and grant_cnt[0]=1.
REQ-029 Reset mid-op: reset asserted in RDATA -> next cycle state IDLE, no ack, all valids 0; a following read completes normally.
